// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port A always wins ties (B may starve).
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int B_WR_LOW  = 0,
  parameter int B_WR_HIGH = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, stateNext;
  logic                lastGrant;   // 0 = port A, 1 = port B
  logic                latWe, latId;
  logic [ADDR_W-1:0]   latAddr;
  logic [DATA_W-1:0]   latWdata;
  logic                doLatch, winB, bReject;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doLatch   = 1'b0;
    winB      = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          doLatch   = 1'b1;
          stateNext = ACCESS;
          if (a_req && b_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            winB = 1'b0;
`else
            winB = !lastGrant;
`endif
          end else begin
            winB = b_req;
          end
        end
      end
      ACCESS: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Out-of-window B writes are squashed but still complete with an error pulse.
  assign bReject = latId && latWe &&
                   ((int'(latAddr) < B_WR_LOW) || (int'(latAddr) > B_WR_HIGH));

  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      a_gnt     = !latId;
      b_gnt     = latId;
      mem_addr  = latAddr;
      mem_wdata = latWdata;
      mem_read  = !latWe;
      mem_write = latWe && !bReject;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant <= 1'b1;
      latWe     <= 1'b0;
      latId     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      b_err  <= 1'b0;
      if (doLatch) begin
        latId     <= winB;
        latWe     <= winB ? b_we    : a_we;
        latAddr   <= winB ? b_addr  : a_addr;
        latWdata  <= winB ? b_wdata : a_wdata;
        lastGrant <= winB;
      end
      // End of the access cycle: report completion and capture read data.
      if (state == ACCESS) begin
        if (latId) begin
          b_done <= 1'b1;
          b_err  <= bReject;
          if (!latWe) b_rdata <= mem_rdata;
        end else begin
          a_done <= 1'b1;
          if (!latWe) a_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
